program_dispatcher: RTL

Receive-side counterpart of the programmer-channel combiner. It pops 801-bit command words from the shared RX FIFO, decodes a channel header in the top bits, and delivers each word to one of four programmer channels through a per-channel valid/ready holding register. It sits between the USB RX FIFO and the four programmer engines, replacing unconditional broadcast of RX data with addressed, flow-controlled delivery.

---
 rtl/program_dispatcher.sv | 80 ++++++++
 1 files changed

// File: rtl/program_dispatcher.sv
// program_dispatcher: pops RX FIFO words and routes each to one of four valid/ready channels; `PROGRAM_DISPATCHER_BCAST_EN enables broadcast
module program_dispatcher #(
  parameter int DATA_W = 801,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_empty,
  output logic              rx_enable,
  output logic [DATA_W-1:0] programmer_data_send0,
  output logic [DATA_W-1:0] programmer_data_send1,
  output logic [DATA_W-1:0] programmer_data_send2,
  output logic [DATA_W-1:0] programmer_data_send3,
  output logic              programmer_send0,
  output logic              programmer_send1,
  output logic              programmer_send2,
  output logic              programmer_send3,
  input  logic              programmer_ready0,
  input  logic              programmer_ready1,
  input  logic              programmer_ready2,
  input  logic              programmer_ready3,
  output logic [CNT_W-1:0]  words_dispatched,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, FETCH, ROUTE} state_t;
  state_t state;
  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] hold [4];
  logic [3:0] send, ready, tgt, load;
  logic go;
  assign ready = {programmer_ready3, programmer_ready2, programmer_ready1, programmer_ready0};
`ifdef PROGRAM_DISPATCHER_BCAST_EN
  assign tgt = word[DATA_W-3] ? 4'hf : 4'b1 << word[DATA_W-1 -: 2];
`else
  assign tgt = 4'b1 << word[DATA_W-1 -: 2];
`endif
  // a target is blocked only while it holds a word its consumer is not taking this cycle
  assign go = (state == ROUTE) && ((tgt & send & ~ready) == 4'b0);
  assign load = go ? tgt : 4'b0;
  assign rx_enable = rst_n && (state == IDLE) && !rx_empty;
  assign busy = state != IDLE;
  assign {programmer_send3, programmer_send2, programmer_send1, programmer_send0} = send;
  assign programmer_data_send0 = hold[0];
  assign programmer_data_send1 = hold[1];
  assign programmer_data_send2 = hold[2];
  assign programmer_data_send3 = hold[3];
  // fetch/route sequencer and dispatched-word counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      word <= '0;
      words_dispatched <= '0;
    end else begin
      case (state)
        IDLE: if (!rx_empty) state <= FETCH;
        FETCH: begin
          word <= rx_data;
          state <= ROUTE;
        end
        ROUTE: if (go) begin
          state <= IDLE;
          words_dispatched <= words_dispatched + CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  // per-channel holding registers; a reload on a transfer edge keeps valid high
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      send <= '0;
      for (int k = 0; k < 4; k++) hold[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++)
        if (load[k]) begin
          hold[k] <= word;
          send[k] <= 1'b1;
        end else if (send[k] && ready[k]) send[k] <= 1'b0;
    end
endmodule
